// File: rtl/fifo_rd_ctrl_pkg.sv
// Shared types and constants for the FIFO read-side controller.
package fifo_rd_ctrl_pkg;

    typedef enum logic [1:0] {RD_IDLE, RD_RUN, RD_DRAIN, RD_DONE} rd_state_e;

    localparam int unsigned FIFO_RD_LATENCY = 1;
    localparam int unsigned SKID_DEPTH      = 2;
    localparam int unsigned SKID_CNT_W      = $clog2(SKID_DEPTH + 1);
    localparam int unsigned STAT_W          = 16;

    // Saturating increment for the statistics counters.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/fifo_rd_ctrl_skid_buf.sv
// Two-entry FIFO-ordered skid buffer with a valid/ready pop side.
module fifo_skid_buf
    import fifo_rd_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_ready,
    output logic                  rd_valid,
    output logic [WIDTH-1:0]      rd_data,
    output logic [SKID_CNT_W-1:0] count
);

    logic [WIDTH-1:0]      mem_q [SKID_DEPTH];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [SKID_CNT_W-1:0] count_q;
    logic                  pop;

    assign rd_valid = (count_q != '0);
    assign rd_data  = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign pop      = rd_valid && rd_ready;

    // When full, a write lands on the slot being popped in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= wr_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + SKID_CNT_W'(wr_en) - SKID_CNT_W'(pop);
        end
    end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side FIFO controller: drains a programmed burst into a valid/ready stream.
// Optional statistics counters are built when FIFO_RD_STATS_EN is defined.
module fifo_rd_ctrl
    import fifo_rd_ctrl_pkg::*;
#(
    parameter int unsigned FIFO_WIDTH = 16,
    parameter int unsigned LEN_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LEN_W-1:0]      burst_len,
    output logic                  busy,
    output logic                  done,
    output logic                  fifo_rd_en,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    output logic                  m_valid,
    output logic [FIFO_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic                  err_underflow,
    output logic [STAT_W-1:0]     stall_cnt,
    output logic [STAT_W-1:0]     empty_wait_cnt
);

    localparam int unsigned CREDIT_W = SKID_CNT_W + 1;

    rd_state_e             state_q, state_d;
    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      issued_q;
    logic [LEN_W-1:0]      delivered_q;
    logic                  inflight_q;
    logic                  err_q;
    logic                  busy_q;
    logic                  done_q;
    logic [SKID_CNT_W-1:0] buf_count;
    logic [CREDIT_W-1:0]   credit_used;
    logic                  buf_wr;
    logic                  uf_drop;
    logic                  pop;

    assign credit_used = CREDIT_W'(buf_count) + CREDIT_W'(inflight_q);
    assign fifo_rd_en  = (state_q == RD_RUN) && !fifo_empty && (issued_q < len_q)
                         && (credit_used < CREDIT_W'(SKID_DEPTH));
    assign buf_wr      = inflight_q && !fifo_underflow;
    assign uf_drop     = inflight_q && fifo_underflow;
    assign pop         = m_valid && m_ready;

    assign busy          = busy_q;
    assign done          = done_q;
    assign err_underflow = err_q;

    fifo_skid_buf #(
        .WIDTH (FIFO_WIDTH)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (buf_wr),
        .wr_data  (fifo_data_out),
        .rd_ready (m_ready),
        .rd_valid (m_valid),
        .rd_data  (m_data),
        .count    (buf_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // RUN waits for the last read to resolve, since an underflow there re-opens issue.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RD_IDLE: begin
                if (start) begin
                    state_d = (burst_len == '0) ? RD_DONE : RD_RUN;
                end
            end
            RD_RUN: begin
                if ((issued_q == len_q) && !inflight_q) begin
                    state_d = RD_DRAIN;
                end
            end
            RD_DRAIN: begin
                if (delivered_q == len_q) begin
                    state_d = RD_DONE;
                end
            end
            RD_DONE: state_d = RD_IDLE;
            default: state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len_q       <= '0;
            issued_q    <= '0;
            delivered_q <= '0;
            inflight_q  <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            inflight_q <= fifo_rd_en;
            busy_q     <= (state_d != RD_IDLE);
            done_q     <= (state_d == RD_DONE);
            if (uf_drop) begin
                err_q <= 1'b1;
            end
            if ((state_q == RD_IDLE) && start) begin
                len_q       <= burst_len;
                issued_q    <= '0;
                delivered_q <= '0;
            end else begin
                issued_q <= issued_q + LEN_W'(fifo_rd_en) - LEN_W'(uf_drop);
                if (pop) begin
                    delivered_q <= delivered_q + LEN_W'(1);
                end
            end
        end
    end

`ifdef FIFO_RD_STATS_EN
    logic [STAT_W-1:0] stall_q;
    logic [STAT_W-1:0] ewait_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
            ewait_q <= '0;
        end else begin
            if (m_valid && !m_ready) begin
                stall_q <= sat_inc(stall_q);
            end
            if ((state_q == RD_RUN) && fifo_empty && (issued_q < len_q)) begin
                ewait_q <= sat_inc(ewait_q);
            end
        end
    end

    assign stall_cnt      = stall_q;
    assign empty_wait_cnt = ewait_q;
`else
    assign stall_cnt      = '0;
    assign empty_wait_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Scoreboard bench for fifo_rd_ctrl with a behavioural 1-cycle-latency FIFO model.
module tb_fifo_rd_ctrl;

    localparam int unsigned W  = 16;
    localparam int unsigned LW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] burst_len = '0;
    logic          busy, done, fifo_rd_en;
    logic          fifo_empty = 1'b1;
    logic          fifo_underflow = 1'b0;
    logic [W-1:0]  fifo_data_out = '0;
    logic          m_valid;
    logic [W-1:0]  m_data;
    logic          m_ready = 1'b1;
    logic          err_underflow;
    logic [15:0]   stall_cnt, empty_wait_cnt;

    logic          wr_en = 1'b0;
    logic [W-1:0]  wr_data = '0;
    logic          inj_arm = 1'b0;
    logic          inj_used = 1'b0;
    logic [W-1:0]  mq[$];
    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  mon_exp;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int rd_cnt = 0;
    int deliv_cnt = 0;

    fifo_rd_ctrl #(.FIFO_WIDTH(W), .LEN_W(LW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .burst_len      (burst_len),
        .busy           (busy),
        .done           (done),
        .fifo_rd_en     (fifo_rd_en),
        .fifo_empty     (fifo_empty),
        .fifo_underflow (fifo_underflow),
        .fifo_data_out  (fifo_data_out),
        .m_valid        (m_valid),
        .m_data         (m_data),
        .m_ready        (m_ready),
        .err_underflow  (err_underflow),
        .stall_cnt      (stall_cnt),
        .empty_wait_cnt (empty_wait_cnt)
    );

    always #5 clk = ~clk;

    // FIFO model: one-cycle read latency; an armed injection fakes an underflow without popping.
    always @(posedge clk) begin
        fifo_underflow <= 1'b0;
        if (!rst_n) begin
            mq.delete();
            fifo_empty <= 1'b1;
        end else begin
            if (wr_en) mq.push_back(wr_data);
            if (fifo_rd_en) begin
                if (inj_arm && !inj_used) begin
                    inj_used = 1'b1;
                    fifo_underflow <= 1'b1;
                    fifo_data_out  <= 16'hDEAD;
                end else if (mq.size() != 0) begin
                    fifo_data_out <= mq.pop_front();
                end else begin
                    fifo_underflow <= 1'b1;
                end
            end
            fifo_empty <= (mq.size() == 0);
        end
    end

    // Monitor: scoreboard pop on each stream transfer, plus event counters.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) done_cnt++;
            if (fifo_rd_en) rd_cnt++;
            if (busy) begin
                checks++;
                if (fifo_rd_en && fifo_empty) begin
                    errors++;
                    $display("FAIL rd_en_while_empty: fifo_rd_en=%0b fifo_empty=%0b, required no read while empty",
                             fifo_rd_en, fifo_empty);
                end
            end
            if (m_valid && m_ready) begin
                checks++;
                deliv_cnt++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL stream_word: got %04h, required no word", m_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (m_data !== mon_exp) begin
                        errors++;
                        $display("FAIL stream_word: got %04h, required %04h", m_data, mon_exp);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [W-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_data = W'(base + W'(i));
            exp_q.push_back(W'(base + W'(i)));
            tick(1);
        end
        wr_en = 1'b0;
        tick(1);
    endtask

    task automatic do_start(input logic [LW-1:0] len);
        start     = 1'b1;
        burst_len = len;
        tick(1);
        start     = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int  base;
        bit  ok;
        base = done_cnt;
        ok   = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick(1);
            if (done_cnt > base) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: no done within %0d cycles, required done pulse", name, budget);
        end
    endtask

    initial begin
        int rd_base, done_base, dv_base;

        // Reset state
        tick(2);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_m_data", 32'(m_data), 0);
        chk("rst_err", 32'(err_underflow), 0);
        chk("rst_rd_en", 32'(fifo_rd_en), 0);
        tick(1);

        // 1: four preloaded words, m_ready high
        preload(16'h0001, 4);
        rd_base = rd_cnt; done_base = done_cnt;
        do_start(8'd4);
        @(negedge clk);
        chk("t1_rd_en_e0", 32'(fifo_rd_en), 1);
        chk("t1_busy", 32'(busy), 1);
        tick(1);
        @(negedge clk);
        chk("t1_valid_e1", 32'(m_valid), 0);
        tick(1);
        @(negedge clk);
        chk("t1_valid_e2", 32'(m_valid), 1);
        chk("t1_data_e2", 32'(m_data), 32'h0001);
        wait_done("t1_done", 60);
        chk("t1_rd_cycles", 32'(rd_cnt - rd_base), 4);
        chk("t1_done_pulses", 32'(done_cnt - done_base), 1);
        chk("t1_sb_empty", 32'(exp_q.size()), 0);
        chk("t1_busy_end", 32'(busy), 0);

        // 2: zero-length burst
        rd_base = rd_cnt;
        do_start(8'd0);
        @(negedge clk);
        chk("t2_done_hi", 32'(done), 1);
        chk("t2_busy_hi", 32'(busy), 1);
        tick(1);
        @(negedge clk);
        chk("t2_done_lo", 32'(done), 0);
        chk("t2_busy_lo", 32'(busy), 0);
        chk("t2_no_reads", 32'(rd_cnt - rd_base), 0);
        tick(1);

        // 3: backpressure for 10 cycles
        m_ready = 1'b0;
        preload(16'h0030, 6);
        rd_base = rd_cnt;
        do_start(8'd6);
        tick(2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t3_hold_valid", 32'(m_valid), 1);
            chk("t3_hold_data", 32'(m_data), 32'h0030);
            tick(1);
        end
        chk("t3_reads_capped", 32'(rd_cnt - rd_base), 2);
        m_ready = 1'b1;
        wait_done("t3_done", 100);
        chk("t3_rd_total", 32'(rd_cnt - rd_base), 6);
        chk("t3_sb_empty", 32'(exp_q.size()), 0);
`ifdef FIFO_RD_STATS_EN
        chk("t3_stall_cnt", 32'(stall_cnt), 10);
`else
        chk("t3_stall_cnt", 32'(stall_cnt), 0);
`endif

        // 4: empty FIFO trickle-fed every 4 cycles
        rd_base = rd_cnt;
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    tick(4);
                    wr_en   = 1'b1;
                    wr_data = W'(16'h0040 + W'(i));
                    exp_q.push_back(W'(16'h0040 + W'(i)));
                    tick(1);
                    wr_en = 1'b0;
                end
            end
            begin
                do_start(8'd3);
                wait_done("t4_done", 200);
            end
        join
        chk("t4_rd_total", 32'(rd_cnt - rd_base), 3);
        chk("t4_sb_empty", 32'(exp_q.size()), 0);
`ifdef FIFO_RD_STATS_EN
        chk("t4_empty_wait_nonzero", 32'(empty_wait_cnt != 0), 1);
`else
        chk("t4_empty_wait_cnt", 32'(empty_wait_cnt), 0);
`endif

        // 5: injected underflow on the first read
        preload(16'h0050, 3);
        rd_base = rd_cnt;
        inj_arm = 1'b1;
        do_start(8'd3);
        wait_done("t5_done", 100);
        inj_arm = 1'b0;
        chk("t5_err", 32'(err_underflow), 1);
        chk("t5_rd_retry", 32'(rd_cnt - rd_base), 4);
        chk("t5_sb_empty", 32'(exp_q.size()), 0);
        tick(2);
        chk("t5_err_sticky", 32'(err_underflow), 1);

        // 6: reset after two of five words
        preload(16'h0060, 5);
        done_base = done_cnt;
        dv_base   = deliv_cnt;
        do_start(8'd5);
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if (deliv_cnt >= dv_base + 2) break;
        end
        chk("t6_two_delivered", 32'(deliv_cnt - dv_base >= 2), 1);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_m_valid", 32'(m_valid), 0);
        chk("t6_m_data", 32'(m_data), 0);
        chk("t6_err_cleared", 32'(err_underflow), 0);
        tick(3);
        chk("t6_no_done", 32'(done_cnt - done_base), 0);
        preload(16'h0070, 1);
        do_start(8'd1);
        wait_done("t6_restart_done", 40);
        chk("t6_sb_empty", 32'(exp_q.size()), 0);

        tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
